// File: rtl/dmem_rmw_responder.sv
// Data-memory responder: word RAM behind a valid/ready port,
// partial stores done as a two-cycle read-modify-write.
module dmem_rmw_responder #(
  parameter int DEPTH = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_wen,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic {
    IDLE,
    MERGE
  } state_t;

  state_t          state_q;
  logic            ready_q;
  logic            rv_q;
  logic            err_q;
  logic            rsel_q;
  logic [IW-1:0]   addr_q;
  logic [3:0]      wen_q;
  logic [31:0]     wdata_q;

  logic [31:0]     mem [DEPTH];
  logic [31:0]     rd_q;

  logic            acc;
  logic            legal;
  logic            inrange;
  logic            bad;
  logic            is_rd;
  logic            is_full;
  logic [IW-1:0]   idx;
  logic [31:0]     mask;
  logic [31:0]     merged;
  logic            re;
  logic            we;
  logic [IW-1:0]   waddr;
  logic [31:0]     wdat;

  // Request classification: lane-mask legality and address range
  always_comb begin
    legal = 1'b0;
    case (req_wen)
      4'b0000, 4'b0001, 4'b0010, 4'b0100,
      4'b1000, 4'b0011, 4'b1100, 4'b1111:
        legal = 1'b1;
      default: legal = 1'b0;
    endcase
    inrange = (req_addr >> (IW + 2)) == 32'd0;
    bad     = !legal || !inrange;
    is_rd   = req_wen == 4'b0000;
    is_full = req_wen == 4'b1111;
    idx     = req_addr[IW+1:2];
    acc     = req_valid && req_ready;
  end

  // Merge captured store lanes over the word read back from RAM
  always_comb begin
    mask = '0;
    for (int i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{wen_q[i]}};
    end
    merged = (wdata_q & mask) | (rd_q & ~mask);
  end

  // RAM port control: reads and writes never share an edge
  always_comb begin
    re    = 1'b0;
    we    = 1'b0;
    waddr = idx;
    wdat  = req_wdata;
    if (state_q == MERGE) begin
      we    = rst;
      waddr = addr_q;
      wdat  = merged;
    end else if (acc && !bad) begin
      re = !is_full;
      we = is_full;
    end
  end

  // Word RAM, no reset, registered read data
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdat;
    end
    if (re) begin
      rd_q <= mem[idx];
    end
  end

  // Control FSM with registered response flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
      rsel_q  <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
      rsel_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (acc) begin
            rv_q <= 1'b1;
            if (bad) begin
              err_q <= 1'b1;
            end else if (is_rd) begin
              rsel_q <= 1'b1;
            end else if (!is_full) begin
              rv_q    <= 1'b0;
              state_q <= MERGE;
              addr_q  <= idx;
              wen_q   <= req_wen;
              wdata_q <= req_wdata;
            end
          end
        end
        MERGE: begin
          rv_q    <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = ready_q && (state_q == IDLE) && rst;
  assign resp_valid = rv_q && rst;
  assign resp_err   = err_q && rst;
  assign resp_rdata = (rsel_q && rst) ? rd_q : 32'd0;

endmodule

// File: tb/tb_dmem_rmw_responder.sv
// Scoreboard bench for dmem_rmw_responder: directed cases
// followed by randomized traffic against a byte-lane memory model.
module tb_dmem_rmw_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [3:0]  req_wen;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  dmem_rmw_responder #(.DEPTH(4096)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_wen    (req_wen),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    bit          chk;
    int          cyc;
    int          id;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          nid = 0;
  logic [31:0] mdl [int];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit legal_wen(input logic [3:0] w);
    return w inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request; model the expected response at acceptance time
  task automatic send(input logic [31:0] a, input logic [3:0] w,
                      input logic [31:0] d, input bit expect_r);
    exp_t        e;
    int          idx;
    int          n;
    logic [31:0] nw;
    req_valid = 1'b1;
    req_addr  = a;
    req_wen   = w;
    req_wdata = d;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: addr %h never accepted", a);
      req_valid = 1'b0;
      return;
    end
    idx     = int'(a[13:2]);
    e.id    = nid++;
    e.chk   = 1'b1;
    e.err   = 1'b0;
    e.rdata = 32'd0;
    e.cyc   = cyc + 1;
    if (!legal_wen(w) || (a >> 14) != 0) begin
      e.err = 1'b1;
    end else if (w == 4'h0) begin
      if (mdl.exists(idx)) e.rdata = mdl[idx];
      else e.chk = 1'b0;
    end else begin
      if (w != 4'hF) e.cyc = cyc + 2;
      if (expect_r) begin
        if (w == 4'hF) begin
          mdl[idx] = d;
        end else if (mdl.exists(idx)) begin
          nw = mdl[idx];
          for (int i = 0; i < 4; i++)
            if (w[i]) nw[8*i +: 8] = d[8*i +: 8];
          mdl[idx] = nw;
        end else begin
          mdl.delete(idx);
        end
      end
    end
    if (expect_r) sb.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Monitor: every response pulse must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (resp_valid) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_resp: err %b rdata %h, none expected",
                 resp_err, resp_rdata);
      end else begin
        e = sb.pop_front();
        if (resp_err !== e.err || (e.chk && resp_rdata !== e.rdata)
            || cyc != e.cyc) begin
          fails++;
          $display("FAIL resp#%0d: err %b rdata %h cyc %0d expected err %b rdata %h cyc %0d",
                   e.id, resp_err, resp_rdata, cyc, e.err, e.rdata, e.cyc);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int words[8] = '{0, 1, 2, 3, 100, 4095, 7, 8};

  initial begin
    logic [31:0] a;
    logic [3:0]  w;
    logic [3:0]  legal_list[8] = '{4'h0, 4'h1, 4'h2, 4'h4,
                                   4'h8, 4'h3, 4'hC, 4'hF};
    int n;
    rst       = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_wen   = '0;
    req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("release_ready_low", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("release_ready_high", {31'd0, req_ready}, 32'd1);

    send(32'h10, 4'hF, 32'hDEADBEEF, 1);
    send(32'h10, 4'h0, 32'h0, 1);

    send(32'h20, 4'hF, 32'h11223344, 1);
    send(32'h20, 4'h2, 32'h0000AA00, 1);
    @(negedge clk);
    chk("merge_ready_low", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    send(32'h20, 4'h0, 32'h0, 1);
    send(32'h20, 4'hC, 32'h55660000, 1);
    send(32'h20, 4'h0, 32'h0, 1);

    send(32'h30, 4'hF, 32'hCAFEF00D, 1);
    send(32'h30, 4'h0, 32'h0, 1);
    send(32'h10, 4'h0, 32'h0, 1);
    send(32'h20, 4'h0, 32'h0, 1);
    send(32'h30, 4'h0, 32'h0, 1);
    send(32'h10, 4'h0, 32'h0, 1);

    send(32'h40, 4'hF, 32'h01020304, 1);
    send(32'h40, 4'h6, 32'hFFFFFFFF, 1);
    send(32'h40, 4'h0, 32'h0, 1);

    send(32'h0000_4000, 4'h0, 32'h0, 1);
    send(32'h0000_3FFC, 4'hF, 32'hA5A55A5A, 1);
    send(32'h0000_3FFC, 4'h0, 32'h0, 1);

    send(32'h50, 4'hF, 32'hFFFFFFFF, 1);
    send(32'h50, 4'h1, 32'h00000012, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("merge_rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("merge_rst_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("post_rst_rdata", resp_rdata, 32'd0);
    chk("post_rst_err", {31'd0, resp_err}, 32'd0);
    @(posedge clk);
    #1;
    send(32'h50, 4'h0, 32'h0, 1);

    foreach (words[i]) send(32'(words[i] * 4), 4'hF, $urandom, 1);
    for (int k = 0; k < 300; k++) begin
      a = 32'(words[$urandom_range(0, 7)] * 4) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) a = $urandom | 32'h4000;
      if ($urandom_range(0, 9) < 7) w = legal_list[$urandom_range(0, 7)];
      else w = 4'($urandom_range(0, 15));
      send(a, w, $urandom, 1);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    n = 0;
    while (sb.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (sb.size() > 0) begin
      fails++;
      $display("FAIL drain: %0d responses missing, 0 expected", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
